spi_regfile_peripheral: RTL and testbench

Parametrised SPI (mode 0) register-file peripheral, the successor of the fixed five-register write-only SPI slave. It receives `1 + ADDR_W + DATA_W`-bit frames from an external controller, synchronised into the `clk` domain. It commits writes into `NUM_REGS` control registers and optionally returns register contents on `cipo`. It sits between the chip pads and the PWM/output-enable logic, and also reports per-register write strobes and a framing-error count.

---
 rtl/spi_regfile_peripheral.sv | 205 ++++++++++++++++++++
 tb/tb_spi_regfile_peripheral.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_peripheral.sv
// spi_regfile_peripheral: SPI mode-0 register-file peripheral.
// Frames are {rw, addr, data}, MSB first, sampled through 2-FF synchronisers into clk.
// Define SPI_READBACK_EN to build the cipo readback path; otherwise cipo/cipo_oe are tied low.
module spi_regfile_peripheral #(
   parameter int unsigned NUM_REGS = 5,
   parameter int unsigned ADDR_W   = 7,
   parameter int unsigned DATA_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ncs,
   input  logic                         sclk,
   input  logic                         copi,
   output logic                         cipo,
   output logic                         cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0]   regs,
   output logic [NUM_REGS-1:0]          wr_strobe,
   output logic [7:0]                   err_count
);

   localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
   localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
   localparam logic [CNT_W-1:0] CntFull = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] CntSat  = CNT_W'(FRAME_W + 1);

   typedef enum logic [1:0] {StIdle, StShift, StCheck} state_e;

   logic [1:0]          ncs_sync_q, sclk_sync_q, copi_sync_q;
   logic                ncs_prev_q, sclk_prev_q;
   logic                ncs_s, sclk_s, copi_s;
   logic                ncs_rise, sclk_rise;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [FRAME_W-1:0]  rx_q, rx_d;

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] strobe_q;
   logic [7:0]          err_q;

   logic                fr_rw;
   logic [ADDR_W-1:0]   fr_addr;
   logic [DATA_W-1:0]   fr_data;
   logic [NUM_REGS-1:0] fr_hit;
   logic                len_ok, addr_ok, do_write, do_err;

   assign ncs_s     = ncs_sync_q[1];
   assign sclk_s    = sclk_sync_q[1];
   assign copi_s    = copi_sync_q[1];
   assign ncs_rise  = ncs_s & ~ncs_prev_q;
   assign sclk_rise = sclk_s & ~sclk_prev_q;

   // Pin synchronisers plus one-cycle-delayed copies for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ncs_sync_q  <= 2'b11;
         sclk_sync_q <= 2'b00;
         copi_sync_q <= 2'b00;
         ncs_prev_q  <= 1'b1;
         sclk_prev_q <= 1'b0;
      end else begin
         ncs_sync_q  <= {ncs_sync_q[0], ncs};
         sclk_sync_q <= {sclk_sync_q[0], sclk};
         copi_sync_q <= {copi_sync_q[0], copi};
         ncs_prev_q  <= ncs_s;
         sclk_prev_q <= sclk_s;
      end
   end

   // Frame FSM next state, bit counter and receive shift register.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rx_d    = rx_q;
      case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (!ncs_s) state_d = StShift;
         end
         StShift: begin
            if (sclk_rise) begin
               rx_d = {rx_q[FRAME_W-2:0], copi_s};
               if (cnt_q != CntSat) cnt_d = cnt_q + 1'b1;
            end
            if (ncs_rise) state_d = StCheck;
         end
         StCheck: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM, counter and receive register state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rx_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rx_q    <= rx_d;
      end
   end

   assign fr_rw   = rx_q[FRAME_W-1];
   assign fr_addr = rx_q[FRAME_W-2 -: ADDR_W];
   assign fr_data = rx_q[DATA_W-1:0];

   // One-hot decode of the frame address; all-zero when the address is out of range.
   always_comb begin
      fr_hit = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         fr_hit[i] = (fr_addr == ADDR_W'(i));
      end
   end

   assign len_ok   = (cnt_q == CntFull);
   assign addr_ok  = |fr_hit;
   assign do_write = (state_q == StCheck) && len_ok && fr_rw && addr_ok;
`ifdef SPI_READBACK_EN
   assign do_err   = (state_q == StCheck) && !(len_ok && addr_ok);
`else
   // Without readback, any correct-length read is dropped quietly.
   assign do_err   = (state_q == StCheck) && !(len_ok && (addr_ok || !fr_rw));
`endif

   // Register commit, write strobes and saturating error counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         strobe_q <= '0;
         err_q    <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (do_write && fr_hit[i]) regs_q[i] <= fr_data;
         end
         strobe_q <= do_write ? fr_hit : '0;
         if (do_err && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
      assign regs[g*DATA_W +: DATA_W] = regs_q[g];
   end

   assign wr_strobe = strobe_q;
   assign err_count = err_q;

`ifdef SPI_READBACK_EN
   localparam logic [CNT_W-1:0] CntPreHdr = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] CntHdr    = CNT_W'(1 + ADDR_W);

   logic                sclk_fall;
   logic                hdr_done, hdr_rw;
   logic [ADDR_W-1:0]   hdr_addr;
   logic [DATA_W-1:0]   rd_data;
   logic [DATA_W-1:0]   tx_q, tx_d;

   assign sclk_fall = ~sclk_s & sclk_prev_q;
   // Header completes on the rising edge that takes the counter to 1+ADDR_W.
   assign hdr_done  = (state_q == StShift) && sclk_rise && (cnt_q == CntPreHdr);
   assign hdr_rw    = rx_d[ADDR_W];
   assign hdr_addr  = rx_d[ADDR_W-1:0];

   // Read mux; out-of-range addresses return zero.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (hdr_addr == ADDR_W'(i)) rd_data = regs_q[i];
      end
   end

   // Transmit register: load on header, then shift on falling edges inside the data field.
   // The falling edge right after the header is skipped so the MSB is held for the
   // controller's first data-field sample.
   always_comb begin
      tx_d = tx_q;
      if (state_q == StIdle) begin
         tx_d = '0;
      end else if (state_q == StShift) begin
         if (hdr_done && !hdr_rw) begin
            tx_d = rd_data;
         end else if (sclk_fall && (cnt_q > CntHdr)) begin
            tx_d = {tx_q[DATA_W-2:0], 1'b0};
         end
      end
   end

   // Transmit shift register state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tx_q <= '0;
      else        tx_q <= tx_d;
   end

   assign cipo_oe = ~ncs_s;
   assign cipo    = cipo_oe & tx_q[DATA_W-1];
`else
   assign cipo_oe = 1'b0;
   assign cipo    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// tb_spi_regfile_peripheral: random and directed SPI frames checked against a
// frame-level model of the register file, write strobes and error counter.
`timescale 1ns/1ps
module tb_spi_regfile_peripheral;

   localparam int NR = 5;
`ifdef SPI_READBACK_EN
   localparam logic RB = 1'b1;
`else
   localparam logic RB = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n, ncs, sclk, copi;
   logic            cipo, cipo_oe;
   logic [NR*8-1:0] regs;
   logic [NR-1:0]   wr_strobe;
   logic [7:0]      err_count;

   int total = 0;
   int bad   = 0;

   logic [7:0] m_regs [NR];
   int         m_err;

   always #5 clk = ~clk;

   spi_regfile_peripheral #(.NUM_REGS(NR), .ADDR_W(7), .DATA_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ncs       (ncs),
      .sclk      (sclk),
      .copi      (copi),
      .cipo      (cipo),
      .cipo_oe   (cipo_oe),
      .regs      (regs),
      .wr_strobe (wr_strobe),
      .err_count (err_count)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [NR*8-1:0] model_flat();
      logic [NR*8-1:0] r;
      for (int i = 0; i < NR; i++) r[i*8 +: 8] = m_regs[i];
      return r;
   endfunction

   task automatic model_bad();
      if (m_err < 255) m_err++;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
      m_err = 0;
   endtask

   // Frame-level rules: only a full-length frame to an existing register does anything.
   task automatic model_frame(input logic [16:0] bits, input int nbits, output logic [NR-1:0] stb);
      logic rw;
      int   addr;
      stb  = '0;
      rw   = bits[15];
      addr = int'(bits[14:8]);
      if (nbits != 16) model_bad();
      else if (addr >= NR) begin
         if (rw || RB) model_bad();
      end else if (rw) begin
         m_regs[addr] = bits[7:0];
         stb[addr]    = 1'b1;
      end
   endtask

   // Controller samples cipo just before raising sclk.
   task automatic send_bit(input logic b, output logic smp);
      sclk = 1'b0;
      copi = b;
      tick(4);
      smp  = cipo;
      sclk = 1'b1;
      tick(4);
   endtask

   task automatic run_frame(input logic [16:0] bits, input int nbits, input bit timed, input int gap);
      logic [NR*8-1:0] old_flat;
      logic [NR-1:0]   stb;
      logic [7:0]      rd, rd_exp;
      logic            s;
      int              addr;
      rd   = '0;
      addr = int'(bits[14:8]);
      ncs  = 1'b0;
      tick(4);
      check_val("cipo_oe_active", cipo_oe, RB);
      for (int i = nbits - 1; i >= 0; i--) begin
         send_bit(bits[i], s);
         if ((nbits - 1 - i) >= 8 && (nbits - 1 - i) < 16) rd = {rd[6:0], s};
      end
      sclk = 1'b0;
      tick(4);
      rd_exp = (RB && addr < NR) ? m_regs[addr] : 8'h00;
      if (nbits == 16 && !bits[15]) check_val("read_data", rd, rd_exp);
      old_flat = model_flat();
      model_frame(bits, nbits, stb);
      ncs = 1'b1;
      if (timed) begin
         tick(3);
         check_val("regs_before_commit", regs, old_flat);
         check_val("strobe_before_commit", wr_strobe, '0);
         tick(1);
         check_val("regs_at_commit", regs, model_flat());
         check_val("strobe_at_commit", wr_strobe, stb);
         tick(1);
         check_val("strobe_one_cycle", wr_strobe, '0);
         check_val("err_count", err_count, m_err);
      end
      tick(gap);
   endtask

   task automatic glitch();
      ncs = 1'b0;
      tick(4);
      ncs = 1'b1;
      model_bad();
      tick(6);
   endtask

   initial begin
      logic [15:0] w;
      logic        s;
      int          len_sel;
      rst_n = 1'b0;
      ncs   = 1'b1;
      sclk  = 1'b0;
      copi  = 1'b0;
      model_reset();
      tick(3);
      check_val("reset_regs", regs, '0);
      check_val("reset_strobe", wr_strobe, '0);
      check_val("reset_err", err_count, 0);
      check_val("reset_cipo", cipo, 1'b0);
      check_val("reset_cipo_oe", cipo_oe, 1'b0);
      rst_n = 1'b1;
      tick(3);

      // Basic write, readback, out-of-range accesses.
      run_frame({1'b0, 16'h80A5}, 16, 1'b1, 4);
      run_frame({1'b0, 16'h843C}, 16, 1'b1, 4);
      run_frame({1'b0, 16'h0400}, 16, 1'b1, 4);
      run_frame({1'b0, 16'h85FF}, 16, 1'b1, 4);
      run_frame({1'b0, 16'h0900}, 16, 1'b1, 4);

      // Short and long frames.
      w = 16'h8277;
      run_frame({2'b00, w[15:1]}, 15, 1'b1, 4);
      run_frame({w, 1'b1}, 17, 1'b1, 4);

      // Reset part-way through a write frame.
      w = 16'h80FF;
      ncs = 1'b0;
      tick(4);
      for (int i = 15; i > 5; i--) send_bit(w[i], s);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_val("midreset_regs", regs, '0);
      check_val("midreset_strobe", wr_strobe, '0);
      check_val("midreset_err", err_count, 0);
      check_val("midreset_cipo", cipo, 1'b0);
      check_val("midreset_cipo_oe", cipo_oe, 1'b0);
      ncs  = 1'b1;
      sclk = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(3);
      run_frame({1'b0, 16'h8112}, 16, 1'b1, 4);

      // Back-to-back frames with a 3-clk ncs high gap.
      run_frame({1'b0, 16'h8211}, 16, 1'b0, 3);
      run_frame({1'b0, 16'h8322}, 16, 1'b0, 3);
      run_frame({1'b0, 16'h8233}, 16, 1'b1, 4);

      // Random frames.
      for (int k = 0; k < 40; k++) begin
         w[15]   = 1'($urandom_range(0, 1));
         w[14:8] = 7'($urandom_range(0, 9));
         w[7:0]  = 8'($urandom);
         len_sel = int'($urandom_range(0, 7));
         if (len_sel == 0)      run_frame({2'b00, w[15:1]}, 15, 1'b1, int'($urandom_range(3, 6)));
         else if (len_sel == 1) run_frame({w, 1'($urandom_range(0, 1))}, 17, 1'b1,
                                          int'($urandom_range(3, 6)));
         else                   run_frame({1'b0, w}, 16, 1'b1, int'($urandom_range(3, 6)));
      end

      // Saturation of the error counter.
      for (int k = 0; k < 256; k++) glitch();
      check_val("err_saturated", err_count, m_err);
      check_val("regs_after_glitches", regs, model_flat());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
